// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - state encoding and sizing helper for the serial magnitude comparator
package cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } cmp_state_t;

  // Bit-index counter width; a single-bit operand still needs a 1-bit index.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/one_bit_comparator.sv
// rtl/one_bit_comparator.sv - one cascade stage of an MSB-first magnitude comparator
module one_bit_comparator (
  input  logic i_gt,
  input  logic i_eq,
  input  logic x,
  input  logic y,
  output logic o_gt,
  output logic o_eq
);

  assign o_gt = i_gt | (i_eq & x & ~y);
  assign o_eq = i_eq & (x ~^ y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - multi-cycle N-bit comparator reusing one cascade cell
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int            IW      = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  cmp_state_t       state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    idx;
  logic             gt_r, eq_r;
  logic             valid_r, res_gt, res_eq;
  logic             bit_a, bit_b;
  logic             cell_gt, cell_eq;
  logic             accept, last_bit;

  assign bit_a = a_r[idx];
  assign bit_b = b_r[idx];

  one_bit_comparator u_cell (
    .i_gt (gt_r),
    .i_eq (eq_r),
    .x    (bit_a),
    .y    (bit_b),
    .o_gt (cell_gt),
    .o_eq (cell_eq)
  );

  // A new request is taken in IDLE and also in DONE, so back-to-back runs lose no cycle.
  assign accept   = start && (state != RUN);
  assign last_bit = (idx == '0) || (EARLY_EXIT && !cell_eq);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = last_bit ? DONE : RUN;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      gt_r    <= 1'b0;
      eq_r    <= 1'b0;
      valid_r <= 1'b0;
      res_gt  <= 1'b0;
      res_eq  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r     <= a;
        b_r     <= b;
        idx     <= IDX_TOP;
        gt_r    <= 1'b0;
        eq_r    <= 1'b1;
        valid_r <= 1'b0;
        res_gt  <= 1'b0;
        res_eq  <= 1'b0;
      end else if (state == RUN) begin
        gt_r <= cell_gt;
        eq_r <= cell_eq;
        if (last_bit) begin
          valid_r <= 1'b1;
          res_gt  <= cell_gt;
          res_eq  <= cell_eq;
        end else begin
          idx <= idx - IW'(1);
        end
      end
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign valid = valid_r;
  assign gt    = res_gt;
  assign eq    = res_eq;
  assign lt    = valid_r & ~res_gt & ~res_eq;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_e = 1'b0, start_f = 1'b0, start_1 = 1'b0;
  logic [3:0] a_e = '0, b_e = '0, a_f = '0, b_f = '0;
  logic [0:0] a_1 = '0, b_1 = '0;
  logic busy_e, done_e, valid_e, gt_e, eq_e, lt_e;
  logic busy_f, done_f, valid_f, gt_f, eq_f, lt_f;
  logic busy_1, done_1, valid_1, gt_1, eq_1, lt_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .a(a_e), .b(b_e),
    .busy(busy_e), .done(done_e), .valid(valid_e), .gt(gt_e), .eq(eq_e), .lt(lt_e)
  );

  serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .a(a_f), .b(b_f),
    .busy(busy_f), .done(done_f), .valid(valid_f), .gt(gt_f), .eq(eq_f), .lt(lt_f)
  );

  serial_magnitude_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) dut_1 (
    .clk(clk), .rst(rst), .start(start_1), .a(a_1), .b(b_1),
    .busy(busy_1), .done(done_1), .valid(valid_1), .gt(gt_1), .eq(eq_1), .lt(lt_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Packs {busy, done, valid, gt, eq, lt} for one-line status checks.
  function automatic logic [5:0] st_e();
    return {busy_e, done_e, valid_e, gt_e, eq_e, lt_e};
  endfunction
  function automatic logic [5:0] st_f();
    return {busy_f, done_f, valid_f, gt_f, eq_f, lt_f};
  endfunction
  function automatic logic [5:0] st_1();
    return {busy_1, done_1, valid_1, gt_1, eq_1, lt_1};
  endfunction

  initial begin
    #12;
    check("reset_e", st_e(), 6'b000000);
    check("reset_f", st_f(), 6'b000000);
    check("reset_1", st_1(), 6'b000000);
    tick();
    rst = 1'b0;
    tick();

    // equal operands, full scan
    a_e = 4'b1010; b_e = 4'b1010; start_e = 1'b1;
    tick(); start_e = 1'b0;
    check("eq_k", st_e(), 6'b100000);
    tick(); tick(); tick();
    check("eq_k3", st_e(), 6'b100000);
    tick();
    check("eq_k4_done", st_e(), 6'b011010);
    tick();
    check("eq_hold", st_e(), 6'b001010);

    // MSB mismatch: early exit vs full scan
    a_e = 4'b1000; b_e = 4'b0111; a_f = 4'b1000; b_f = 4'b0111;
    start_e = 1'b1; start_f = 1'b1;
    tick(); start_e = 1'b0; start_f = 1'b0;
    tick();
    check("early_k1_done", st_e(), 6'b011100);
    check("full_k1_busy", st_f(), 6'b100000);
    tick(); tick();
    check("early_hold", st_e(), 6'b001100);
    tick();
    check("full_k4_done", st_f(), 6'b011100);

    // 3 < 5, operand change during RUN ignored
    tick();
    a_f = 4'd3; b_f = 4'd5; start_f = 1'b1;
    tick(); start_f = 1'b0; a_f = 4'd15;
    tick(); tick(); tick();
    check("lt_k3", st_f(), 6'b100000);
    tick();
    check("lt_k4_done", st_f(), 6'b011001);

    // start held high: ignored in RUN, accepted in DONE
    a_e = 4'd9; b_e = 4'd9; start_e = 1'b1;
    tick();
    tick(); tick(); tick();
    check("hold_k3", st_e(), 6'b100000);
    tick();
    check("hold_k4_done", st_e(), 6'b011010);
    tick();
    check("hold_k5_rerun", st_e(), 6'b100000);
    tick(); tick(); tick(); tick();
    check("hold_k9_done", st_e(), 6'b011010);
    tick();
    check("hold_k10_rerun", st_e(), 6'b100000);
    tick();

    // reset in the second RUN cycle of the third run
    rst = 1'b1; start_e = 1'b0;
    #1;
    check("async_rst", st_e(), 6'b000000);
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("no_done_after_rst", st_e(), 6'b000000);

    // 2 > 1, mismatch at bit 1
    a_e = 4'd2; b_e = 4'd1; start_e = 1'b1;
    tick(); start_e = 1'b0;
    tick(); tick();
    check("gt_k2", st_e(), 6'b100000);
    tick();
    check("gt_k3_done", st_e(), 6'b011100);

    // single-bit operands
    a_1 = 1'b1; b_1 = 1'b0; start_1 = 1'b1;
    tick(); start_1 = 1'b0;
    check("w1_k", st_1(), 6'b100000);
    tick();
    check("w1_gt_done", st_1(), 6'b011100);
    tick();
    a_1 = 1'b0; b_1 = 1'b0; start_1 = 1'b1;
    tick(); start_1 = 1'b0;
    check("w1_rerun_valid_low", st_1(), 6'b100000);
    tick();
    check("w1_eq_done", st_1(), 6'b011010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Multi-cycle N-bit magnitude comparator built around one instance of the existing one_bit_comparator cascade cell. It walks two latched operands MSB-first, one bit per clock, and feeds the registered gt/eq state back into the cell's cascade inputs. A start/busy/done handshake lets a host FSM or a shared-resource arbiter run comparisons without unrolling WIDTH comparator cells.

Parameters:
WIDTH, 4, operand width in bits (>=1)
EARLY_EXIT, 1, 1 = finish at the first differing bit; 0 = always scan all WIDTH bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request comparison; sampled only when not busy
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result becomes valid
valid  output  1  result outputs valid; held until next accepted start
gt  output  1  A > B (valid only when valid=1)
eq  output  1  A == B
lt  output  1  A < B

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, valid, gt, eq, lt = 0; operand regs and counter = 0. Asserting rst mid-RUN aborts the operation immediately and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at a clock edge: latch a_r=a, b_r=b; idx=WIDTH-1; gt_r=0; eq_r=1; valid=0; go to RUN.
- RUN (busy=1): the cell sees i_gt=gt_r, i_eq=eq_r, x=a_r[idx], y=b_r[idx].
  - Cell behaviour: o_gt = i_gt | (i_eq & x & ~y); o_eq = i_eq & (x ~^ y).
  - Each edge: gt_r<=o_gt; eq_r<=o_eq.
  - If idx==0, or EARLY_EXIT=1 and o_eq=0: go to DONE. Otherwise idx<=idx-1.
  - start is ignored while in RUN.
- DONE: done=1 for exactly this cycle; valid=1; gt=gt_r, eq=eq_r, lt=~gt_r&~eq_r.
  - start=1 in DONE is accepted the same way as in IDLE (latch, go to RUN). done still pulses that cycle.
  - Otherwise go to IDLE. valid and results hold in IDLE.
- Latency, with start accepted at edge k:
  - Full scan: done high in the cycle after edge k+WIDTH.
  - Early exit with the first mismatch at bit p: done high after edge k+(WIDTH-p).
- idx width is $clog2(WIDTH), minimum 1 bit. idx never wraps below 0.
- gt, eq, lt are mutually exclusive; exactly one of them is 1 when valid=1. All three are 0 when valid=0.
- Changing a or b after start has no effect on the result.

Decomposition:
- Shared package cmp_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module: one instance of the existing one_bit_comparator, connected with port order (i_gt, i_eq, x, y, o_gt, o_eq).
- All sequencing, counter and result registers live in serial_magnitude_comparator.

Test Plan:
- WIDTH=4, a=4'b1010, b=4'b1010, start pulse at edge k -> busy for 4 cycles; done pulse after edge k+4; eq=1, gt=0, lt=0, valid=1 held afterwards.
- WIDTH=4, EARLY_EXIT=1, a=4'b1000, b=4'b0111 -> done after edge k+1; gt=1, eq=0, lt=0. With EARLY_EXIT=0, same result with done after edge k+4.
- WIDTH=4, EARLY_EXIT=0, a=4'd3, b=4'd5 -> lt=1 after edge k+4. Changing a to 4'd15 during RUN does not change the result.
- start held high continuously with a=4'd9, b=4'd9 -> second start is ignored during RUN, accepted in DONE; valid drops for the second run; done pulses every 5 cycles.
- rst pulsed during the second RUN cycle -> all outputs 0 asynchronously; no done. A new start after reset with a=4'd2, b=4'd1 gives gt=1.
- WIDTH=1: a=1, b=0 -> gt=1, done after edge k+1. a=0, b=0 -> eq=1.
